// File: rtl/accum_sum_controller_pkg.sv
// Shared definitions for the accumulator controller: widths, FSM encoding
// and the 7-segment glyph lookup used by the display drivers.
package accum_sum_controller_pkg;

   localparam int OPERAND_W = 8;
   localparam int COUNT_W   = 4;
   localparam int SEG_W     = 7;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_FULL  = 2'd2,
      ST_OVF   = 2'd3
   } state_e;

   // Active-high segment pattern, bit order {g,f,e,d,c,b,a}
   function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] nib);
      logic [SEG_W-1:0] seg;
      case (nib)
         4'h0: seg = 7'h3F;
         4'h1: seg = 7'h06;
         4'h2: seg = 7'h5B;
         4'h3: seg = 7'h4F;
         4'h4: seg = 7'h66;
         4'h5: seg = 7'h6D;
         4'h6: seg = 7'h7D;
         4'h7: seg = 7'h07;
         4'h8: seg = 7'h7F;
         4'h9: seg = 7'h6F;
         4'hA: seg = 7'h77;
         4'hB: seg = 7'h7C;
         4'hC: seg = 7'h39;
         4'hD: seg = 7'h5E;
         4'hE: seg = 7'h79;
         default: seg = 7'h71;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/button_handler_down.sv
// Turns a raw active-low push button into a single-cycle pulse per press.
module button_handler_down (
   input  logic clock,
   input  logic reset,
   input  logic button_i,
   output logic pulse_o
);

   logic btn_q;
   logic btn_prev_q;

   // Sample the button and keep one cycle of history; idle level is high
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         btn_q      <= 1'b1;
         btn_prev_q <= 1'b1;
      end else begin
         btn_q      <= button_i;
         btn_prev_q <= btn_q;
      end
   end

   // A press is the high-to-low transition of the sampled button
   assign pulse_o = btn_prev_q & ~btn_q;

endmodule

// File: rtl/hex22digit.sv
// Drives two 7-segment digits showing a byte in hexadecimal.
module hex22digit
   import accum_sum_controller_pkg::*;
(
   input  logic [7:0]         hex_i,
   output logic [2*SEG_W-1:0] digits_o
);

   // Upper digit shows the high nibble, lower digit the low nibble
   always_comb begin
      digits_o = {hex_to_seg(hex_i[7:4]), hex_to_seg(hex_i[3:0])};
   end

endmodule

// File: rtl/accum_sum_controller.sv
// Button-driven 8-bit accumulator with operand counting, saturation after
// MAX_OPERANDS adds and a sticky overflow state; all values shown on 7-seg.
module accum_sum_controller
   import accum_sum_controller_pkg::*;
#(
   parameter int unsigned MAX_OPERANDS = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 button_add,
   input  logic                 button_clear,
   input  logic [OPERAND_W-1:0] switch_0,
   output logic [2*SEG_W-1:0]   digits_0,
   output logic [2*SEG_W-1:0]   digits_1,
   output logic [2*SEG_W-1:0]   digits_2,
   output logic                 overload,
   output logic [1:0]           state
);

   localparam logic [COUNT_W-1:0] MAX_CNT = COUNT_W'(MAX_OPERANDS);

   logic                 flag_add;
   logic                 flag_clear;
   logic [OPERAND_W-1:0] number_q;
   logic [OPERAND_W-1:0] acc_q,   acc_d;
   logic [COUNT_W-1:0]   count_q, count_d;
   state_e               state_q, state_d;
   logic [OPERAND_W:0]   sum9;
   logic [COUNT_W-1:0]   count_inc;

   button_handler_down u_btn_add (
      .clock    (clock),
      .reset    (reset),
      .button_i (button_add),
      .pulse_o  (flag_add)
   );

   button_handler_down u_btn_clear (
      .clock    (clock),
      .reset    (reset),
      .button_i (button_clear),
      .pulse_o  (flag_clear)
   );

   // State, accumulator, count and operand registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         acc_q    <= '0;
         count_q  <= '0;
         number_q <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         count_q  <= count_d;
         number_q <= switch_0;
      end
   end

   // Next-state logic: clear wins over add; adds only land in IDLE/ACCUM
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      count_d   = count_q;
      sum9      = {1'b0, acc_q} + {1'b0, number_q};
      count_inc = count_q + 1'b1;
      if (flag_clear) begin
         state_d = ST_IDLE;
         acc_d   = '0;
         count_d = '0;
      end else if (flag_add && (state_q == ST_IDLE || state_q == ST_ACCUM)) begin
         acc_d   = sum9[OPERAND_W-1:0];
         count_d = count_inc;
         if (sum9[OPERAND_W])
            state_d = ST_OVF;
         else if (count_inc == MAX_CNT)
            state_d = ST_FULL;
         else
            state_d = ST_ACCUM;
      end
   end

   assign state    = state_q;
   assign overload = (state_q == ST_OVF);

   // Three display pairs: operand, accumulator, zero-extended count
   logic [7:0]         hex_in  [3];
   logic [2*SEG_W-1:0] hex_out [3];

   assign hex_in[0] = number_q;
   assign hex_in[1] = acc_q;
   assign hex_in[2] = {{(8-COUNT_W){1'b0}}, count_q};

   for (genvar gi = 0; gi < 3; gi++) begin : g_disp
      hex22digit u_hex (
         .hex_i    (hex_in[gi]),
         .digits_o (hex_out[gi])
      );
   end

   assign digits_0 = hex_out[0];
   assign digits_1 = hex_out[1];
   assign digits_2 = hex_out[2];

endmodule
